mcyc_maindec: RTL
=================

# mcyc_maindec

Multicycle main control unit for the MIPS core. It replaces the single-cycle combinational main decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It talks to a shared instruction/data memory through a req/ready handshake and adds BNE, ANDI, ORI and JAL. It sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables.

## Interface
- EXT_OPS, 1: 1 decodes BNE/ANDI/ORI/JAL; 0 treats them as illegal.
- MEM_TIMEOUT, 0: max wait cycles per memory access; 0 disables the timeout.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode from the instruction register, instr[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, mem_we, iord  out  1  memory request, write, address select (1 = ALUOut).
- irwrite, pcwrite  out  1  IR load, unconditional PC load.
- branch, branch_ne  out  1  PC load if ALU zero / not zero.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alusrca  out  1  0 PC, 1 rs.
- alusrcb  out  2  00 rt, 01 const 4, 10 imm, 11 sign-ext imm<<2.
- zeroext  out  1  imm is zero-extended.
- aluop  out  2  00 add, 01 sub, 10 funct, 11 logic-by-op.
- regdst, wbsel  out  2  regdst: 00 rt, 01 rd, 10 r31. wbsel: 00 ALUOut, 01 MDR, 10 PC.
- regwrite, illegal_op, mem_err  out  1  register write, illegal-op pulse, timeout pulse.
- state  out  4  current state, for debug.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, J 000010, JAL 000011.
- Any output not listed for a state is 0.
- FETCH: mem_req, alusrcb=01. When mem_ready=1, irwrite=1 and pcwrite=1 (Mealy), then go to DECODE; otherwise stay.
- DECODE: alusrcb=11. Next state:
  - MEMADR for LW/SW
  - EXEC for R-type
  - BRANCH for BEQ/BNE
  - IMMEX for ADDI/ANDI/ORI
  - JUMP for J/JAL
  - ILLEGAL for anything else
- MEMADR: alusrca=1, alusrcb=10; go to MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req, iord; on ready go to MEMWB.
- MEMWB: regwrite, regdst=00, wbsel=01; go to FETCH.
- MEMWR: mem_req, mem_we, iord; on ready go to FETCH.
- EXEC: alusrca=1, aluop=10; go to ALUWB.
- ALUWB: regwrite, regdst=01; go to FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01; branch=1 for BEQ, branch_ne=1 for BNE; go to FETCH.
- IMMEX: alusrca=1, alusrcb=10.
  - ADDI: aluop=00.
  - ANDI/ORI: aluop=11, zeroext=1.
  - Go to IMMWB.
- IMMWB: regwrite, regdst=00, zeroext held as in IMMEX; go to FETCH.
- JUMP: pcsrc=10, pcwrite. For JAL also regwrite, regdst=10, wbsel=10 (PC already holds PC+4). Go to FETCH.
- ILLEGAL: illegal_op=1 for one cycle; go to FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle mem_ready=0. Width is clog2(MEM_TIMEOUT+1).
  - When it equals MEM_TIMEOUT (nonzero): mem_err=1 for one cycle, mem_req=0 that cycle, and the FSM goes to FETCH.
  - A fetch timeout retries the same PC, because pcwrite never asserted.
  - If mem_ready=1 on the timeout cycle, the completion wins and no error is raised.

## Timing
- Reset: while rst=1 every output is 0 and state=FETCH (encoding 0); the counter clears.
- First mem_req is in the first cycle after rst falls.
- rst mid-access: the request drops in the same cycle and no writeback occurs.
- Latency at zero wait (mem_ready high on the first request cycle):
  - R/ADDI/ANDI/ORI/SW: 4 cycles
  - LW: 5 cycles
  - BEQ/BNE/J/JAL/illegal: 3 cycles
- Each memory wait cycle adds 1.
- mem_req stays high and iord/mem_we stay stable until the ready cycle. No new request is raised in the cycle after a completion, except a FETCH that directly follows MEMWR.

## Test plan
- Reset, then R-type (op=000000) with mem_ready always 1:
  - states FETCH, DECODE, EXEC, ALUWB, FETCH
  - regwrite=1 and regdst=01 only in ALUWB
- LW with 2 wait cycles in each of FETCH and MEMRD:
  - 9 cycles total
  - mem_req high through the waits; irwrite pulses once; iord=1 only in MEMRD
- JAL with EXT_OPS=1:
  - JUMP cycle shows pcwrite=1, pcsrc=10, regwrite=1, regdst=10, wbsel=10
- JAL with EXT_OPS=0:
  - ILLEGAL state, illegal_op one-cycle pulse, then FETCH
  - no regwrite or pcwrite after FETCH
- MEM_TIMEOUT=3, SW with mem_ready stuck low:
  - mem_err pulses in the 4th MEMWR cycle with mem_req=0 that cycle
  - next state FETCH; no mem_we outside MEMWR
- rst asserted during MEMWB of an LW:
  - regwrite=0 from that cycle on
  - after release: FETCH with mem_req=1 and counter cleared

Source files
------------

// File: rtl/mcyc_maindec.sv
// Multicycle MIPS main control unit: Moore sequencer over fetch/decode/
// execute/memory/writeback with a req/ready memory handshake and an
// optional per-access wait timeout.
module mcyc_maindec #(
  parameter int EXT_OPS     = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] aluop,
  output logic [1:0] regdst,
  output logic [1:0] wbsel,
  output logic       regwrite,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);
  localparam bit EXT = (EXT_OPS != 0);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wait_st;
  logic          timeout;
  logic          logic_imm;

  // Next-state, wait counter and timeout detection
  always_comb begin
    wait_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout   = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (cnt_q == TO_VAL);
    logic_imm = (op == OP_ANDI) || (op == OP_ORI);
    // counter is zero outside wait states, so it is already clear on entry
    cnt_d     = (wait_st && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;
    state_d   = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_R:            state_d = S_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_BNE:          state_d = EXT ? S_BRANCH : S_ILLEGAL;
          OP_ADDI:         state_d = S_IMMEX;
          OP_ANDI, OP_ORI: state_d = EXT ? S_IMMEX : S_ILLEGAL;
          OP_J:            state_d = S_JUMP;
          OP_JAL:          state_d = EXT ? S_JUMP : S_ILLEGAL;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IMMEX: state_d = S_IMMWB;
      default: state_d = S_FETCH;
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs decoded from state; forced low while rst is high so an
  // in-flight request or writeback is cancelled in the reset cycle itself
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroext    = 1'b0;
    aluop      = 2'b00;
    regdst     = 2'b00;
    wbsel      = 2'b00;
    regwrite   = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    state      = rst ? 4'd0 : state_q;
    if (!rst) begin
      mem_err = timeout;
      case (state_q)
        S_FETCH: begin
          mem_req = !timeout;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_req = !timeout;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          wbsel    = 2'b01;
        end
        S_MEMWR: begin
          mem_req = !timeout;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 2'b01;
        end
        S_BRANCH: begin
          alusrca   = 1'b1;
          aluop     = 2'b01;
          pcsrc     = 2'b01;
          branch    = (op == OP_BEQ);
          branch_ne = (op == OP_BNE);
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = logic_imm ? 2'b11 : 2'b00;
          zeroext = logic_imm;
        end
        S_IMMWB: begin
          regwrite = 1'b1;
          zeroext  = logic_imm;
        end
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          if (op == OP_JAL) begin
            regwrite = 1'b1;
            regdst   = 2'b10;
            wbsel    = 2'b10;
          end
        end
        S_ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
